// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
//   arb_state_t : arbiter state (IDLE = no owner, BUSY = one producer owns the port)
//   idx_width() : bits needed to index N items, never less than 1
//   cnt_width() : burst-counter width, one bit wider than the index width so
//                 that MAX_BURST = 256 still fits
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int max_burst);
        return $clog2(max_burst) + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotating-priority picker.
//   req    : request vector
//   base   : index that has highest priority; search goes upward with wrap
//   found  : at least one request is set
//   idx    : index of the winning request (0 when nothing found)
//   onehot : one-hot of idx (all-zero when nothing found)
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] base,
    output logic          found,
    output logic [IW-1:0] idx,
    output logic [N-1:0]  onehot
);

    // cand[k] is the producer index sitting k places after base.
    // base and k are both below N, so the sum fits in IW+1 bits and one
    // conditional subtract performs the wrap.
    logic [IW-1:0] cand [N];
    logic [N-1:0]  rot_req;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
            logic [IW:0] sum;
            logic [IW:0] wrapped;
            assign sum        = {1'b0, base} + (IW+1)'(gi);
            assign wrapped    = (sum >= (IW+1)'(N)) ? sum - (IW+1)'(N) : sum;
            assign cand[gi]   = wrapped[IW-1:0];
            assign rot_req[gi] = req[cand[gi]];
        end
    endgenerate

    // Scan from the far end down so the closest candidate to base wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                found = 1'b1;
                idx   = cand[k];
            end
        end
    end

    generate
        for (gi = 0; gi < N; gi++) begin : g_onehot
            assign onehot[gi] = found && (idx == IW'(gi));
        end
    endgenerate

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N_REQ producers.
// A producer is granted the port for a burst of up to MAX_BURST accepted
// words; the grant rotates when the burst completes or the owner runs dry.
//   clk      : clock, all state on posedge
//   rst      : asynchronous active-low reset
//   req      : per-producer valid, data held stable until acked
//   req_data : producer i data at [i*Width +: Width]
//   full     : FIFO full flag
//   ack      : per-producer acceptance (word moves on the edge where ack[i]=1)
//   grant    : registered one-hot owner, zero when idle
//   wr_en    : FIFO write enable
//   d_in     : FIFO write data, zero when not writing
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int Width     = 8,
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*Width-1:0] req_data,
    input  logic                   full,
    output logic [N_REQ-1:0]       ack,
    output logic [N_REQ-1:0]       grant,
    output logic                   wr_en,
    output logic [Width-1:0]       d_in
);

    localparam int IW = idx_width(N_REQ);
    localparam int CW = cnt_width(MAX_BURST);
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    arb_state_t       state_reg,    state_next;
    logic [N_REQ-1:0] grant_reg,    grant_next;
    logic [IW-1:0]    owner_reg,    owner_next;
    logic [IW-1:0]    rr_base_reg,  rr_base_next;
    logic [CW-1:0]    beat_cnt_reg, beat_cnt_next;

    logic [IW-1:0]    owner_inc;
    logic [IW-1:0]    pick_base;
    logic             pick_found;
    logic [IW-1:0]    pick_idx;
    logic [N_REQ-1:0] pick_onehot;
    logic             owner_req;
    logic             release_now;
    logic [Width-1:0] data_arr [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_data
            assign data_arr[gi] = req_data[gi*Width +: Width];
            assign ack[gi]      = wr_en && grant_reg[gi];
        end
    endgenerate

    assign owner_inc = (owner_reg == IW'(N_REQ - 1)) ? '0 : owner_reg + IW'(1);

    // One picker serves both cases: from IDLE it searches from rr_base, while
    // BUSY it is only consulted on release, where the search starts just past
    // the current owner (which is also the new rr_base).
    assign pick_base = (state_reg == BUSY) ? owner_inc : rr_base_reg;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .req    (req),
        .base   (pick_base),
        .found  (pick_found),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    assign owner_req = req[owner_reg];
    assign wr_en     = (state_reg == BUSY) && owner_req && !full;
    assign d_in      = wr_en ? data_arr[owner_reg] : '0;
    assign grant     = grant_reg;

    // Owner drop wins over a stall: a full FIFO does not keep an idle owner.
    assign release_now = (wr_en && (beat_cnt_reg == LAST_BEAT)) || !owner_req;

    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        owner_next    = owner_reg;
        rr_base_next  = rr_base_reg;
        beat_cnt_next = beat_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    state_next    = BUSY;
                    grant_next    = pick_onehot;
                    owner_next    = pick_idx;
                    beat_cnt_next = '0;
                end
            end
            BUSY: begin
                if (release_now) begin
                    rr_base_next = owner_inc;
                    if (pick_found) begin
                        // Hand over without an idle bubble.
                        grant_next    = pick_onehot;
                        owner_next    = pick_idx;
                        beat_cnt_next = '0;
                    end else begin
                        state_next    = IDLE;
                        grant_next    = '0;
                        beat_cnt_next = '0;
                    end
                end else if (wr_en) begin
                    beat_cnt_next = beat_cnt_reg + CW'(1);
                end
            end
            default: begin
                state_next    = IDLE;
                grant_next    = '0;
                beat_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            grant_reg    <= '0;
            owner_reg    <= '0;
            rr_base_reg  <= '0;
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            owner_reg    <= owner_next;
            rr_base_reg  <= rr_base_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_data = '0;
    logic           full = 1'b0;
    logic [N-1:0]   ack;
    logic [N-1:0]   grant;
    logic           wr_en;
    logic [W-1:0]   d_in;

    fifo_wr_arbiter #(
        .Width     (W),
        .N_REQ     (N),
        .MAX_BURST (MB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .full     (full),
        .ack      (ack),
        .grant    (grant),
        .wr_en    (wr_en),
        .d_in     (d_in)
    );

    always #5 clk = ~clk;

    // Producer word stores
    logic [W-1:0] pmem [N][32];
    int           head [N];
    int           tail [N];
    logic [N-1:0] mask;

    // Words the DUT actually wrote into the FIFO
    logic [W-1:0] dut_log [64];
    int           log_n;
    int           cyc, first_wr, last_wr;

    // Behavioural model of the arbiter
    bit m_busy;
    int m_owner, m_base, m_cnt;

    int checks = 0;
    int passes = 0;

    logic [W-1:0] e_seq [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push(input int p, input logic [W-1:0] v);
        pmem[p][tail[p]] = v;
        tail[p]++;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            req[i] = mask[i] && (head[i] != tail[i]);
            req_data[i*W +: W] = req[i] ? pmem[i][head[i]] : '0;
        end
    endtask

    function automatic int pick(input int from);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (from + k) % N;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_base = 0; m_cnt = 0;
    endtask

    // One clock cycle: compare at negedge, advance model, drive next inputs.
    task automatic step();
        logic         m_wr;
        logic [N-1:0] eg, ea;
        logic [W-1:0] ed;
        int           p;
        bit           rel;
        @(negedge clk);
        m_wr = m_busy && req[m_owner] && !full;
        eg   = m_busy ? (N'(1) << m_owner) : '0;
        ea   = m_wr ? eg : '0;
        ed   = m_wr ? pmem[m_owner][head[m_owner]] : '0;
        chk("grant", 32'(grant), 32'(eg));
        chk("ack",   32'(ack),   32'(ea));
        chk("wr_en", 32'(wr_en), 32'(m_wr));
        chk("d_in",  32'(d_in),  32'(ed));
        if (wr_en && log_n < 64) begin
            dut_log[log_n] = d_in;
            log_n++;
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
        end
        if (!m_busy) begin
            p = pick(m_base);
            if (p >= 0) begin m_busy = 1; m_owner = p; m_cnt = 0; end
        end else begin
            rel = (m_wr && m_cnt == MB - 1) || !req[m_owner];
            if (rel) begin
                m_base = (m_owner + 1) % N;
                p = pick(m_base);
                if (p >= 0) begin m_owner = p; m_cnt = 0; end
                else begin m_busy = 0; m_cnt = 0; end
            end else if (m_wr) begin
                m_cnt++;
            end
        end
        if (m_wr) head[m_owner == m_owner ? m_owner : 0] += 0;
        if (m_wr) head[eg == '0 ? 0 : $clog2(eg)]++;
        cyc++;
        @(posedge clk);
        #1;
        drive_inputs();
        #1;
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((m_busy || req != '0) && n < bound) begin
            step();
            n++;
        end
        if (n >= bound) begin
            checks++;
            $display("FAIL drain: still busy after %0d cycles, expected idle", bound);
        end
        chk("drain_idle_grant", 32'(grant), 32'h0);
    endtask

    task automatic do_reset();
        rst  = 1'b0;
        mask = '0;
        full = 1'b0;
        for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end
        drive_inputs();
        #1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_ack",   32'(ack),   32'h0);
        chk("rst_wr_en", 32'(wr_en), 32'h0);
        chk("rst_d_in",  32'(d_in),  32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        log_n = 0; first_wr = -1; last_wr = -1;
        drive_inputs();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0;
        #2;

        // Reset mid-burst
        do_reset();
        for (int k = 0; k < 6; k++) push(1, 8'h10 + 8'(k));
        mask = 4'b0010;
        drive_inputs();
        #1;
        step(); step(); step();
        chk("t1_two_beats", 32'(log_n), 32'd2);
        rst = 1'b0;
        #1;
        chk("t1_rst_grant", 32'(grant), 32'h0);
        chk("t1_rst_ack",   32'(ack),   32'h0);
        chk("t1_rst_wr_en", 32'(wr_en), 32'h0);
        model_reset();
        rst = 1'b1;
        step();
        chk("t1_regrant", 32'(grant), 32'b0010);
        drain(40);
        e_seq = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        chk("t1_count", 32'(log_n), 32'd6);
        for (int k = 0; k < 6; k++) chk("t1_word", 32'(dut_log[k]), 32'(e_seq[k]));

        // Single producer, 6 words across the 4-beat boundary
        do_reset();
        for (int k = 0; k < 6; k++) push(2, 8'hA0 + 8'(k));
        mask = 4'b0100;
        drive_inputs();
        #1;
        drain(40);
        e_seq = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        chk("t2_count", 32'(log_n), 32'd6);
        for (int k = 0; k < 6; k++) chk("t2_word", 32'(dut_log[k]), 32'(e_seq[k]));
        chk("t2_no_bubble", 32'(last_wr - first_wr), 32'd5);

        // Round robin with all four requesting
        do_reset();
        for (int p = 0; p < N; p++)
            for (int k = 0; k < 8; k++) push(p, 8'(p * 16 + k));
        mask = 4'b1111;
        drive_inputs();
        #1;
        for (int c = 1; c <= 17; c++) begin
            logic [N-1:0] exp_g;
            step();
            exp_g = N'(1) << (((c - 1) / 4) % 4);
            chk("t3_grant_seq", 32'(grant), 32'(exp_g));
            chk("t3_wr_every_cycle", 32'(wr_en), 32'h1);
        end
        drain(80);
        chk("t3_count", 32'(log_n), 32'd32);

        // Back-pressure on owner 1
        do_reset();
        for (int k = 0; k < 6; k++) push(1, 8'h40 + 8'(k));
        push(2, 8'h50); push(2, 8'h51);
        mask = 4'b0110;
        drive_inputs();
        #1;
        step(); step(); step();
        full = 1'b1;
        #1;
        for (int s = 0; s < 3; s++) begin
            if (s > 0) step();
            chk("t4_stall_wr_en", 32'(wr_en), 32'h0);
            chk("t4_stall_ack",   32'(ack),   32'h0);
            chk("t4_stall_grant", 32'(grant), 32'b0010);
        end
        step();
        full = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("t4_resume_wr_en", 32'(wr_en), 32'h1);
            step();
        end
        chk("t4_words", 32'(log_n), 32'd4);
        chk("t4_rotate", 32'(grant), 32'b0100);
        drain(40);

        // Early drop by owner 0 while producer 3 waits
        do_reset();
        push(0, 8'h60); push(0, 8'h61);
        push(3, 8'h70); push(3, 8'h71); push(3, 8'h72);
        mask = 4'b1001;
        drive_inputs();
        #1;
        step(); step(); step();
        chk("t5_drop_wr_en", 32'(wr_en), 32'h0);
        step();
        chk("t5_grant", 32'(grant), 32'b1000);
        chk("t5_ack",   32'(ack),   32'b1000);
        chk("t5_d_in",  32'(d_in),  32'h70);
        chk("t5_model_base", 32'(m_base), 32'd1);
        drain(40);

        // Priority from rr_base = 2
        do_reset();
        push(1, 8'h80);
        mask = 4'b0010;
        drive_inputs();
        #1;
        drain(20);
        chk("t6_model_base", 32'(m_base), 32'd2);
        push(1, 8'h81); push(3, 8'h90);
        mask = 4'b1010;
        drive_inputs();
        #1;
        step();
        chk("t6_grant", 32'(grant), 32'b1000);
        chk("t6_d_in",  32'(d_in),  32'h90);
        drain(40);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the team's synchronous FIFO between N_REQ producers.
- Each producer presents a valid/ack stream; the arbiter locks one owner for a burst of up to MAX_BURST accepted words, then rotates.
- Drives FIFO wr_en/d_in and honours FIFO full.
- Sits directly in front of the FIFO and is verified with the same clocking-block style bench.

Parameters:
- Width, 8, data word width; matches the FIFO Width.
- N_REQ, 4, number of producers (2..16).
- MAX_BURST, 4, maximum accepted words per grant (1..256).

Ports:
- clk  in  1  single clock, all state on posedge.
- rst  in  1  reset; asynchronous assert, active-low (0 = reset).
- req  in  N_REQ  per-producer valid; held with stable data until acked.
- req_data  in  N_REQ*Width  producer i data at bits [i*Width +: Width].
- full  in  1  FIFO full flag.
- ack  out  N_REQ  per-producer acceptance; word transferred on a clk edge when ack[i]=1.
- grant  out  N_REQ  registered one-hot current owner; all-zero when idle.
- wr_en  out  1  FIFO write enable.
- d_in  out  Width  FIFO write data.

Behaviour:
- Reset state:
  - state=IDLE, grant=0, rr_base=0 (producer 0 highest priority), beat_cnt=0.
  - Consequently ack=0, wr_en=0, d_in=0.
  - Reset asserted mid-burst clears state immediately; the in-flight word is not written.
- States:
  - IDLE: no owner.
  - BUSY: owner = index of grant, beat_cnt counts accepted words.
- Combinational outputs:
  - wr_en = (state==BUSY) & req[owner] & !full.
  - ack[owner] = wr_en; all other ack bits = 0.
  - d_in = req_data[owner] when wr_en, else 0.
- IDLE -> BUSY:
  - If any req is set at the edge, pick the first set req searching from rr_base upward with wrap.
  - grant <= onehot(pick), beat_cnt <= 0.
  - First ack possible the cycle after req is seen (1-cycle arbitration latency).
- BUSY, release conditions, evaluated at each edge:
  - (a) wr_en & beat_cnt==MAX_BURST-1: accepted final beat of the burst.
  - (b) !req[owner]: owner has nothing pending.
- On release:
  - rr_base <= owner+1 mod N_REQ.
  - Pick the next owner from owner+1 using the current req vector.
  - If a req is set, go straight to BUSY with the new owner and beat_cnt=0 (no idle bubble). The same producer may re-win when it is the only requester.
  - Otherwise go to IDLE, grant=0.
- BUSY, no release: beat_cnt increments on wr_en only. Stalled cycles (full=1) do not count, and grant holds while full.
- Simultaneous events:
  - Release and a new req arriving at the same edge: the new req takes part in that edge's pick.
  - full and owner-drop at the same edge: release per (b).
- Width rules:
  - beat_cnt width = $clog2(MAX_BURST)+1, so MAX_BURST=256 fits.
  - rr_base and owner width = $clog2(N_REQ) (min 1).
- Invariants:
  - grant has at most one bit set.
  - ack is a subset of grant.
  - wr_en never asserts when full=1.
  - At most MAX_BURST consecutive accepted words per grant.

Decomposition:
- Package fifo_arb_pkg holds:
  - the state enum (IDLE, BUSY);
  - an index-width function wrapping $clog2 with a minimum of 1;
  - the burst-counter width constant function.
- One sub-module, rr_pick: combinational rotating-priority picker.
  - Inputs: req vector, base index.
  - Outputs: found bit, picked index, one-hot.
  - Used for both the IDLE pick and the release pick.

Test Plan:
- Reset mid-burst:
  - Stimulus: N_REQ=4, MAX_BURST=4; req[1]=1 for 2 acked beats, then pull rst low between edges.
  - Required: grant, ack and wr_en go to 0 immediately.
  - Required after release with req[1] still set: grant=0010 again one edge later, beat count restarts.
- Single producer:
  - Stimulus: req[2] with 6 words 0xA0..0xA5.
  - Required: FIFO receives 0xA0..0xA5 in order with no bubble at the 4-beat burst boundary.
  - Required: grant=0100 throughout, then grant=0000 one edge after the last ack.
- Round robin:
  - Stimulus: req=1111 continuously.
  - Required: grant sequence 0001(4 beats), 0010(4), 0100(4), 1000(4), 0001.
  - Required: wr_en=1 every cycle after the first.
- Back-pressure:
  - Stimulus: owner 1, full=1 for 3 cycles after beat 2.
  - Required: wr_en=0 and ack=0 during the stall, grant stays 0010.
  - Required: exactly 2 more words after full drops, then rotation.
- Early drop:
  - Stimulus: owner 0 drops req after 2 beats while req[3]=1.
  - Required: next edge grant=1000, first ack[3] that cycle, rr_base=1.
- Priority from base:
  - Stimulus: IDLE with rr_base=2; req[1] and req[3] rise together.
  - Required: grant=1000 (producer 3 wins).
